// File: rtl/reaction_round_ctrl_if.sv
// Signal bundle between the reaction-game sequencer and its surroundings:
// button front-end and start in, timer control and display data out.
interface reaction_round_ctrl_if;
    localparam int unsigned BTN_W   = 4;
    localparam int unsigned TIME_W  = 10;
    localparam int unsigned SCORE_W = 8;
    localparam int unsigned LIVES_W = 3;

    logic               start;
    logic [BTN_W-1:0]   btn;
    logic               timer_done;
    logic               timer_manual_resetn;
    logic [TIME_W-1:0]  max_time;
    logic [1:0]         target;
    logic               target_valid;
    logic [SCORE_W-1:0] score;
    logic [LIVES_W-1:0] lives;
    logic               game_over;
    logic [2:0]         state_dbg;

    modport master (
        output start, btn, timer_done,
        input  timer_manual_resetn, max_time, target, target_valid,
               score, lives, game_over, state_dbg
    );

    modport slave (
        input  start, btn, timer_done,
        output timer_manual_resetn, max_time, target, target_valid,
               score, lives, game_over, state_dbg
    );
endinterface

// File: rtl/reaction_round_ctrl.sv
// Reaction game round sequencer: picks targets, arms the countdown timer,
// judges presses, and keeps score, lives and the shrinking time limit.
module reaction_round_ctrl #(
    parameter int unsigned START_TIME   = 10,
    parameter int unsigned MIN_TIME     = 2,
    parameter int unsigned STEP         = 1,
    parameter int unsigned LEVEL_ROUNDS = 5,
    parameter int unsigned LIVES        = 3,
    parameter logic [7:0]  LFSR_SEED    = 8'hA5
) (
    input  logic                  clk,
    input  logic                  reset,
    reaction_round_ctrl_if.slave  bus
);
    localparam int unsigned TIME_W = 10;
    localparam int unsigned LVL_W  = (LEVEL_ROUNDS > 1) ? $clog2(LEVEL_ROUNDS) : 1;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ARM       = 3'd1,
        PLAY      = 3'd2,
        HIT       = 3'd3,
        MISS      = 3'd4,
        GAME_OVER = 3'd5
    } state_t;

    state_t            state, state_n;
    logic [7:0]        lfsr, lfsr_n;
    logic [1:0]        target, target_n;
    logic [7:0]        score, score_n;
    logic [2:0]        lives, lives_n;
    logic [TIME_W-1:0] max_time, max_time_n;
    logic [LVL_W-1:0]  level, level_n;
    logic              tmr_rstn_q, target_valid_q, game_over_q;

    logic [1:0]        pick_c;
    logic [3:0]        target_onehot_c;
    logic              can_step_c;

    // New target never repeats the previous one
    assign pick_c          = (lfsr[1:0] == target) ? lfsr[1:0] + 2'd1 : lfsr[1:0];
    assign target_onehot_c = 4'(1) << target;
    assign can_step_c      = {1'b0, max_time} >= 11'(MIN_TIME + STEP);

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            lfsr           <= LFSR_SEED;
            target         <= 2'd0;
            score          <= 8'd0;
            lives          <= 3'd0;
            max_time       <= TIME_W'(START_TIME);
            level          <= '0;
            tmr_rstn_q     <= 1'b0;
            target_valid_q <= 1'b0;
            game_over_q    <= 1'b0;
        end else begin
            state          <= state_n;
            lfsr           <= lfsr_n;
            target         <= target_n;
            score          <= score_n;
            lives          <= lives_n;
            max_time       <= max_time_n;
            level          <= level_n;
            tmr_rstn_q     <= (state_n == PLAY);
            target_valid_q <= (state_n == PLAY);
            game_over_q    <= (state_n == GAME_OVER);
        end
    end

    always_comb begin
        state_n    = state;
        lfsr_n     = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
        target_n   = target;
        score_n    = score;
        lives_n    = lives;
        max_time_n = max_time;
        level_n    = level;

        case (state)
            IDLE, GAME_OVER: begin
                if (bus.start) begin
                    state_n    = ARM;
                    target_n   = pick_c;
                    score_n    = 8'd0;
                    lives_n    = 3'(LIVES);
                    max_time_n = TIME_W'(START_TIME);
                    level_n    = '0;
                end
            end
            ARM: state_n = PLAY;
            PLAY: begin
                // Correct press wins even when the timer expires in the same cycle
                if (bus.btn == target_onehot_c) begin
                    state_n = HIT;
                    score_n = (score == 8'hFF) ? score : score + 8'd1;
                    if (level == LVL_W'(LEVEL_ROUNDS - 1)) begin
                        level_n    = '0;
                        max_time_n = can_step_c ? max_time - TIME_W'(STEP)
                                                : TIME_W'(MIN_TIME);
                    end else begin
                        level_n = level + LVL_W'(1);
                    end
                end else if (bus.btn != 4'd0 || bus.timer_done) begin
                    state_n = MISS;
                    lives_n = lives - 3'd1;
                end
            end
            HIT: begin
                state_n  = ARM;
                target_n = pick_c;
            end
            MISS: begin
                if (lives == 3'd0) begin
                    state_n = GAME_OVER;
                end else begin
                    state_n  = ARM;
                    target_n = pick_c;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign bus.timer_manual_resetn = tmr_rstn_q;
    assign bus.max_time            = max_time;
    assign bus.target              = target;
    assign bus.target_valid        = target_valid_q;
    assign bus.score               = score;
    assign bus.lives               = lives;
    assign bus.game_over           = game_over_q;
    assign bus.state_dbg           = state;
endmodule

// File: tb/tb_reaction_round_ctrl.sv
// Randomized bench for reaction_round_ctrl against a game-rule model.
module tb_reaction_round_ctrl;
    localparam int START_TIME   = 10;
    localparam int MIN_TIME     = 2;
    localparam int STEP         = 1;
    localparam int LEVEL_ROUNDS = 5;
    localparam int LIVES        = 3;
    localparam int SEED         = 8'hA5;

    localparam int S_IDLE = 0, S_ARM = 1, S_PLAY = 2, S_HIT = 3, S_MISS = 4, S_OVER = 5;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    reaction_round_ctrl_if bus ();

    reaction_round_ctrl #(
        .START_TIME(START_TIME), .MIN_TIME(MIN_TIME), .STEP(STEP),
        .LEVEL_ROUNDS(LEVEL_ROUNDS), .LIVES(LIVES), .LFSR_SEED(8'hA5)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Game-level model of what the outputs must show after the next edge
    int m_state, m_lfsr, m_target, m_score, m_lives, m_max, m_hits_in_level;
    int last_arm_target;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int next_target(input int lfsr, input int prev);
        int cand = lfsr % 4;
        return (cand == prev) ? (cand + 1) % 4 : cand;
    endfunction

    task automatic model_step(input bit rst, input bit st, input int b, input bit td);
        int fb = ((m_lfsr >> 7) ^ (m_lfsr >> 5) ^ (m_lfsr >> 4) ^ (m_lfsr >> 3)) & 1;
        int new_lfsr = ((m_lfsr * 2) % 256) + fb;
        if (rst) begin
            m_state = S_IDLE; m_lfsr = SEED; m_target = 0; m_score = 0;
            m_lives = 0; m_max = START_TIME; m_hits_in_level = 0;
            return;
        end
        case (m_state)
            S_IDLE, S_OVER: if (st) begin
                m_score = 0; m_lives = LIVES; m_max = START_TIME; m_hits_in_level = 0;
                m_target = next_target(m_lfsr, m_target);
                m_state = S_ARM;
            end
            S_ARM: m_state = S_PLAY;
            S_PLAY: begin
                if (b == (1 << m_target)) begin
                    m_score = (m_score + 1 > 255) ? 255 : m_score + 1;
                    m_hits_in_level++;
                    if (m_hits_in_level == LEVEL_ROUNDS) begin
                        m_hits_in_level = 0;
                        m_max = (m_max - STEP < MIN_TIME) ? MIN_TIME : m_max - STEP;
                    end
                    m_state = S_HIT;
                end else if (b != 0 || td) begin
                    m_lives--;
                    m_state = S_MISS;
                end
            end
            S_HIT: begin
                m_target = next_target(m_lfsr, m_target);
                m_state = S_ARM;
            end
            S_MISS: begin
                if (m_lives == 0) m_state = S_OVER;
                else begin
                    m_target = next_target(m_lfsr, m_target);
                    m_state = S_ARM;
                end
            end
            default: m_state = S_IDLE;
        endcase
        m_lfsr = new_lfsr;
    endtask

    task automatic drive(input bit rst, input bit st, input int b, input bit td);
        reset          = rst;
        bus.start      = st;
        bus.btn        = 4'(b);
        bus.timer_done = td;
        model_step(rst, st, b, td);
    endtask

    task automatic compare_all();
        check("state_dbg",    int'(bus.state_dbg), m_state);
        check("timer_rstn",   int'(bus.timer_manual_resetn), int'(m_state == S_PLAY));
        check("max_time",     int'(bus.max_time), m_max);
        check("target",       int'(bus.target), m_target);
        check("target_valid", int'(bus.target_valid), int'(m_state == S_PLAY));
        check("score",        int'(bus.score), m_score);
        check("lives",        int'(bus.lives), m_lives);
        check("game_over",    int'(bus.game_over), int'(m_state == S_OVER));
        if (bus.state_dbg == 3'(S_ARM)) begin
            check("no_repeat", int'(int'(bus.target) != last_arm_target), 1);
            last_arm_target = int'(bus.target);
        end
        if (reset) last_arm_target = 0;
    endtask

    // Random press while in PLAY: correct / wrong-or-multi / none
    function automatic int play_btn(input int pct_correct, input int pct_wrong);
        int r = int'($urandom_range(99, 0));
        int w;
        if (r < pct_correct) return 1 << m_target;
        if (r < pct_correct + pct_wrong) begin
            w = int'($urandom_range(15, 1));
            if (w == (1 << m_target)) w = 15;
            return w;
        end
        return 0;
    endfunction

    initial begin
        int b;
        last_arm_target = 0;
        drive(1, 0, 0, 0);

        // Reset values, first start, first target from the seed, first hit
        @(negedge clk);
        compare_all();
        check("lit_rst_state", int'(bus.state_dbg), 0);
        check("lit_rst_tmr",   int'(bus.timer_manual_resetn), 0);
        check("lit_rst_max",   int'(bus.max_time), 10);
        check("lit_rst_lives", int'(bus.lives), 0);
        check("lit_rst_score", int'(bus.score), 0);
        drive(0, 1, 0, 0);
        @(negedge clk);
        compare_all();
        check("lit_arm_state", int'(bus.state_dbg), 1);
        check("lit_arm_tmr",   int'(bus.timer_manual_resetn), 0);
        check("lit_arm_lives", int'(bus.lives), 3);
        drive(0, 0, 4'b0100, 1);
        @(negedge clk);
        compare_all();
        check("lit_play_state",  int'(bus.state_dbg), 2);
        check("lit_play_valid",  int'(bus.target_valid), 1);
        check("lit_play_tmr",    int'(bus.timer_manual_resetn), 1);
        check("lit_play_target", int'(bus.target), 1);
        check("lit_play_max",    int'(bus.max_time), 10);
        drive(0, 0, 4'b0010, 0);
        @(negedge clk);
        compare_all();
        check("lit_hit_state", int'(bus.state_dbg), 3);
        check("lit_hit_score", int'(bus.score), 1);
        check("lit_hit_lives", int'(bus.lives), 3);
        drive(0, 0, 0, 0);

        // Always-correct play: level-ups, floor and score saturation
        for (int i = 0; i < 900; i++) begin
            @(negedge clk);
            compare_all();
            if (m_state == S_HIT && m_score == 5)
                check("lit_level1_max", int'(bus.max_time), 9);
            if (m_state == S_HIT && m_score == 45)
                check("lit_floor_max", int'(bus.max_time), 2);
            b = (m_state == S_PLAY) ? (1 << m_target) : int'($urandom_range(15, 0));
            drive(0, ($urandom_range(99, 0) < 20), b, ($urandom_range(99, 0) < 25));
        end
        check("lit_score_sat", int'(bus.score), 255);
        check("lit_no_loss",   int'(bus.lives), 3);

        // Fully random play with misses, game-overs, restarts and resets
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            compare_all();
            b = (m_state == S_PLAY) ? play_btn(45, 20) : int'($urandom_range(15, 0));
            drive(($urandom_range(199, 0) == 0), ($urandom_range(99, 0) < 12), b,
                  ($urandom_range(99, 0) < 15));
        end
        @(negedge clk);
        compare_all();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/reaction_round_ctrl.md
Name: reaction_round_ctrl

Overview:
- Game-level sequencer for the reaction game. Drives the one-second countdown timer through its `max_time` and `manual_resetn` inputs, and receives its `timer_done`.
- Each round: picks a pseudo-random target (1 of 4), arms the timer, judges the player's button press against it, and tracks score and lives.
- Per-round time limit shrinks as the player progresses.
- Sits between the debounced button front-end and the timer/HEX display path.

Parameters:
- START_TIME, 10, initial per-round limit in seconds (10-bit, >= MIN_TIME)
- MIN_TIME, 2, floor for per-round limit (must be >= 1)
- STEP, 1, seconds removed from limit per level-up
- LEVEL_ROUNDS, 5, correct hits per level-up (>= 1)
- LIVES, 3, lives per game (1..7)
- LFSR_SEED, 8'hA5, LFSR reset value (non-zero)

Ports:
- clk  in  1  system clock (50 MHz)
- reset  in  1  synchronous, active-high; one clock; reset is synchronous and active-high
- start  in  1  one-cycle pulse; starts a new game
- btn  in  4  one-cycle press pulses, already synchronised and debounced
- timer_done  in  1  from timer, high while timer value == 0
- timer_manual_resetn  out  1  to timer manual_resetn, active-low; timer loads max_time on a clk edge while low
- max_time  out  10  per-round limit in seconds, to timer
- target  out  2  index of lit target
- target_valid  out  1  high only in PLAY
- score  out  8  correct hits this game, saturates at 255
- lives  out  3  remaining lives
- game_over  out  1  high in GAME_OVER
- state_dbg  out  3  current state encoding (IDLE=0, ARM=1, PLAY=2, HIT=3, MISS=4, GAME_OVER=5)

Behaviour:
- Reset values (any state, any cycle):
  - state IDLE, timer_manual_resetn 0, max_time START_TIME, target 0, target_valid 0
  - score 0, lives 0, game_over 0, level counter 0, LFSR LFSR_SEED
- LFSR:
  - 8-bit, free-running every cycle (including IDLE).
  - Shift left; new bit0 = q[7]^q[5]^q[4]^q[3].
- Target pick (on ARM entry):
  - candidate = lfsr[1:0].
  - If candidate == previous target, target = candidate+1 (mod 4).
  - The first pick after reset compares against 0.
- timer_manual_resetn:
  - Low in IDLE, ARM, HIT, MISS, GAME_OVER; high only in PLAY.
  - max_time is stable for the whole ARM cycle, so the timer holds exactly max_time on PLAY entry.
- IDLE: start -> ARM; on that edge: score=0, lives=LIVES, max_time=START_TIME, level counter=0.
- ARM (exactly 1 cycle): target latched, btn and timer_done ignored -> PLAY.
- PLAY: target_valid=1. Priority within a cycle:
  - btn == one-hot(target) -> HIT.
  - else btn != 0 (wrong button, or multiple bits set) -> MISS.
  - else timer_done -> MISS.
  - Correct press coincident with timer_done counts as HIT.
  - start is ignored in PLAY.
- HIT (1 cycle):
  - score = min(score+1, 255).
  - If level counter == LEVEL_ROUNDS-1: counter = 0 and max_time = max(max_time-STEP, MIN_TIME), computed without 10-bit underflow. Otherwise counter+1.
  - -> ARM.
- MISS (1 cycle): lives = lives-1. If the result is 0 -> GAME_OVER, else -> ARM.
- GAME_OVER:
  - game_over=1, target_valid=0; score and lives hold for display.
  - start -> ARM with the same clear as from IDLE.
- Latency:
  - start to target_valid high: 2 cycles (IDLE->ARM->PLAY).
  - Hit or miss to next target_valid: 2 cycles (HIT/MISS->ARM->PLAY).
- Inputs outside IDLE/PLAY/GAME_OVER: btn and start have no effect.
- Reset asserted mid-round: next state IDLE and all reset values apply, regardless of btn, start or timer_done in the same cycle.

Test Plan:
- Reset then start pulse → 2 cycles later state_dbg=2, target_valid=1, lives=3, score=0, max_time=10. timer_manual_resetn is low during ARM and high in PLAY.
- In PLAY, drive btn=one-hot(target) for 1 cycle → next cycle HIT, score=1. Then ARM, then PLAY, with the new target != old target. Repeat 20 times; no consecutive repeats.
- 5 correct hits → max_time 10→9. Use START_TIME=3, MIN_TIME=2, 15 hits → max_time sequence 3,2,2 (floor holds, no wrap).
- Hold btn=0 with the timer scaled to a small CLOCK_FREQUENCY until timer_done → MISS, lives 3→2. Wrong button (e.g. 4'b1111) → MISS, lives 2→1. Third miss → GAME_OVER, game_over=1, score held.
- Correct btn in the same cycle as timer_done → HIT, lives unchanged. btn pulse during ARM → ignored, still reaches PLAY.
- Assert reset while in PLAY with score=7 → next cycle IDLE, score=0, lives=0, timer_manual_resetn=0. From GAME_OVER, a start pulse → ARM with score=0, lives=3.
